// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle: {pc, instr} pairs in, head entry out, plus flush and occupancy.
interface if_id_buffer_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic               flush;
  logic [1:0]         count;

  modport master (
    output pc_in, instr_in, in_valid, out_ready, flush,
    input  in_ready, out_valid, pc_out, instr_out, count
  );

  modport slave (
    input  pc_in, instr_in, in_valid, out_ready, flush,
    output in_ready, out_valid, pc_out, instr_out, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// 2-entry in-order IF/ID FIFO; 1-cycle latency, in_ready = not full (registered only), flush clears occupancy.
// Optional IF_ID_BUFFER_BYPASS_EN: an empty buffer forwards the incoming pair to decode combinationally.
module if_id_buffer #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input logic           clk,
  input logic           reset,
  if_id_buffer_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t     mem [2];
  entry_t     head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       bypass;
  logic       push;
  logic       pop;

  assign head         = mem[rd_ptr];
  assign bus.in_ready = (cnt != 2'd2);
  assign bus.count    = cnt;

`ifdef IF_ID_BUFFER_BYPASS_EN
  assign bypass = (cnt == 2'd0) && bus.in_valid && !bus.flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    pop  = (cnt != 2'd0) && bus.out_ready && !bus.flush;
    // A bypassed pair taken by decode in the same cycle never occupies a slot.
    push = bus.in_valid && bus.in_ready && !bus.flush && !(bypass && bus.out_ready);
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.pc_out    = '0;
    bus.instr_out = '0;
    if (cnt != 2'd0) begin
      bus.out_valid = 1'b1;
      bus.pc_out    = head.pc;
      bus.instr_out = head.instr;
    end else if (bypass) begin
      bus.out_valid = 1'b1;
      bus.pc_out    = bus.pc_in;
      bus.instr_out = bus.instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (bus.flush) begin
      // Storage is left intact; only occupancy is cleared.
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: bus.pc_in, instr: bus.instr_in};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer; expectations follow the bypass macro when it is defined.
module tb_if_id_buffer;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  if_id_buffer_if #(.PC_W(64), .INSTR_W(32)) bus ();

  if_id_buffer #(.PC_W(64), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic drive(input logic [63:0] pc, input logic vld);
    bus.pc_in    = pc;
    bus.instr_in = mk_instr(pc);
    bus.in_valid = vld;
  endtask

  initial begin
    reset         = 1'b1;
    bus.pc_in     = '0;
    bus.instr_in  = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pc_out", bus.pc_out, 64'd0);
    chk("rst_instr_out", 64'(bus.instr_out), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Popping an empty buffer has no effect
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("empty_pop_count", 64'(bus.count), 64'd0);

    // Single push, one-cycle latency
    drive(64'h0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("push0_out_valid", 64'(bus.out_valid), 64'd1);
    chk("push0_pc_out", bus.pc_out, 64'h0);
    chk("push0_instr_out", 64'(bus.instr_out), 64'h13);
    chk("push0_count", 64'(bus.count), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain0_count", 64'(bus.count), 64'd0);

    // Fill to two, third pair stalls
    drive(64'h4, 1'b1);
    tick();
    drive(64'h8, 1'b1);
    tick();
    drive(64'hC, 1'b1);
    chk("full_count", 64'(bus.count), 64'd2);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("full_hold_count", 64'(bus.count), 64'd2);
    chk("full_head_pc", bus.pc_out, 64'h4);
    bus.out_ready = 1'b1;
    tick();
    chk("order_pc_2nd", bus.pc_out, 64'h8);
    chk("order_instr_2nd", 64'(bus.instr_out), 64'(mk_instr(64'h8)));
    chk("order_count", 64'(bus.count), 64'd1);
    tick();
    bus.out_ready = 1'b0;
    chk("drained_count", 64'(bus.count), 64'd0);
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);
    chk("drained_pc_out", bus.pc_out, 64'd0);

    // Simultaneous push and pop at count=1
    drive(64'h10, 1'b1);
    tick();
    drive(64'h14, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("pushpop_count", 64'(bus.count), 64'd1);
    chk("pushpop_pc_out", bus.pc_out, 64'h14);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Flush at count=2 drops the same-cycle push
    drive(64'h18, 1'b1);
    tick();
    drive(64'h1C, 1'b1);
    tick();
    drive(64'h20, 1'b1);
    bus.flush = 1'b1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_pc_out", bus.pc_out, 64'd0);
    drive(64'h24, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("postflush_pc_out", bus.pc_out, 64'h24);
    chk("postflush_count", 64'(bus.count), 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush1_count", 64'(bus.count), 64'd0);

    // Reset and flush together at count=2
    drive(64'h28, 1'b1);
    tick();
    drive(64'h2C, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    bus.flush    = 1'b1;
    tick();
    reset     = 1'b0;
    bus.flush = 1'b0;
    chk("rstflush_count", 64'(bus.count), 64'd0);
    chk("rstflush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rstflush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstflush_instr_out", 64'(bus.instr_out), 64'd0);
    drive(64'h30, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("postrst_pc_out", bus.pc_out, 64'h30);
    chk("postrst_count", 64'(bus.count), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Empty buffer, valid input with decode ready
    drive(64'h40, 1'b1);
    bus.out_ready = 1'b1;
    #1;
`ifdef IF_ID_BUFFER_BYPASS_EN
    chk("byp_same_out_valid", 64'(bus.out_valid), 64'd1);
    chk("byp_same_pc_out", bus.pc_out, 64'h40);
`else
    chk("byp_same_out_valid", 64'(bus.out_valid), 64'd0);
    chk("byp_same_pc_out", bus.pc_out, 64'd0);
`endif
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef IF_ID_BUFFER_BYPASS_EN
    chk("byp_next_count", 64'(bus.count), 64'd0);
    chk("byp_next_out_valid", 64'(bus.out_valid), 64'd0);
`else
    chk("byp_next_count", 64'(bus.count), 64'd1);
    chk("byp_next_pc_out", bus.pc_out, 64'h40);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("final_count", 64'(bus.count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
